// File: rtl/lock_pkg.sv
// Shared state encoding and width helper for the combination-lock sequencer.
package lock_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        SHOW1    = 3'd1,
        SHOW2    = 3'd2,
        ENTRY    = 3'd3,
        UNLOCKED = 3'd4,
        LOCKOUT  = 3'd5
    } lock_state_t;

    // Ceiling log2, never less than 1 so it can size a register directly.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/lock_sequencer_btn_sync_edge.sv
// Two-flop synchroniser for the raw next button followed by a rising-edge detector.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchronise the button into clk and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign press = sync2 & ~sync3;

endmodule

// File: rtl/lock_sequencer.sv
// Combination-lock sequencer: display stepping, password check, failure count,
// timed lockout and optional auto-relock after unlocking.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 50000000,
    parameter int unsigned UNLOCK_TIMEOUT = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                btn_next,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]       digits_shown,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]       digits_pw,
    output logic [STATE_W-1:0]                  state,
    output logic                                unlocked,
    output logic                                locked_out,
    output logic [clog2(MAX_ATTEMPTS+1)-1:0]    fail_cnt,
    output logic                                attempt_fail
);

    localparam int unsigned FC_W = clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned LT_W = clog2(LOCKOUT_CYCLES);
    localparam int unsigned UT_W = clog2(UNLOCK_TIMEOUT + 1);

    lock_state_t     state_q, state_nxt;
    logic [FC_W-1:0] fail_nxt;
    logic [LT_W-1:0] lock_tmr, lock_nxt;
    logic [UT_W-1:0] unl_tmr, unl_nxt;
    logic            fail_pulse_nxt;
    logic            press;
    logic            code_match;
    logic            last_try;
    logic            relock;

    btn_sync_edge u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_next),
        .press  (press)
    );

    // Whole-word equality is a match on every digit at once.
    assign code_match = (digits_shown == digits_pw);
    assign last_try   = ((32'(fail_cnt) + 32'd1) == MAX_ATTEMPTS);
    assign relock     = (UNLOCK_TIMEOUT != 0) && (unl_tmr <= UT_W'(1));

    // State, failure counter, timers and failure pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fail_cnt     <= '0;
            lock_tmr     <= '0;
            unl_tmr      <= '0;
            attempt_fail <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            fail_cnt     <= fail_nxt;
            lock_tmr     <= lock_nxt;
            unl_tmr      <= unl_nxt;
            attempt_fail <= fail_pulse_nxt;
        end
    end

    // Next-state, counter and timer update.
    always_comb begin
        state_nxt      = state_q;
        fail_nxt       = fail_cnt;
        lock_nxt       = lock_tmr;
        unl_nxt        = unl_tmr;
        fail_pulse_nxt = 1'b0;
        case (state_q)
            IDLE:  if (press) state_nxt = SHOW1;
            SHOW1: if (press) state_nxt = SHOW2;
            SHOW2: if (press) state_nxt = ENTRY;
            ENTRY: begin
                if (press) begin
                    if (code_match) begin
                        state_nxt = UNLOCKED;
                        fail_nxt  = '0;
                        unl_nxt   = UT_W'(UNLOCK_TIMEOUT);
                    end else begin
                        fail_pulse_nxt = 1'b1;
                        if (last_try) begin
                            state_nxt = LOCKOUT;
                            fail_nxt  = FC_W'(MAX_ATTEMPTS);
                            lock_nxt  = LT_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            fail_nxt = fail_cnt + 1'b1;
                        end
                    end
                end
            end
            UNLOCKED: begin
                // Press and time-out both lead to IDLE, so a coincidence needs no arbitration.
                if (UNLOCK_TIMEOUT != 0 && unl_tmr != '0) unl_nxt = unl_tmr - 1'b1;
                if (press || relock) state_nxt = IDLE;
            end
            LOCKOUT: begin
                if (lock_tmr == '0) begin
                    state_nxt = IDLE;
                    fail_nxt  = '0;
                end else begin
                    lock_nxt = lock_tmr - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign state      = state_q;
    assign unlocked   = (state_q == UNLOCKED);
    assign locked_out = (state_q == LOCKOUT);

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
Parametrised combination-lock sequencer. Steps the display state on each press of the next button and compares the digits being shown against the stored password. Counts failed attempts and enters a timed lockout after a set number of failures. Optionally relocks itself after a time-out once open. Sits between the button and digit-select logic and the 7-segment display and LED drivers.

Parameters:
NUM_DIGITS, 8, number of password digits compared
DIGIT_W, 4, bits per digit
MAX_ATTEMPTS, 3, consecutive failures that trigger lockout (must be >= 1)
LOCKOUT_CYCLES, 50000000, clk cycles spent in LOCKOUT (must be >= 1)
UNLOCK_TIMEOUT, 0, clk cycles before UNLOCKED relocks by itself; 0 disables the time-out

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
btn_next  in  1  raw, asynchronous next button, active-high
digits_shown  in  NUM_DIGITS*DIGIT_W  digits currently entered; digit 0 is in bits [DIGIT_W-1:0]
digits_pw  in  NUM_DIGITS*DIGIT_W  stored password, same packing as digits_shown
state  out  3  current state encoding
unlocked  out  1  high while state is UNLOCKED
locked_out  out  1  high while state is LOCKOUT
fail_cnt  out  clog2(MAX_ATTEMPTS+1)  consecutive failed attempts
attempt_fail  out  1  one-cycle pulse on each mismatching check

Behaviour:
- Reset: state=IDLE(0), fail_cnt=0, timers=0, attempt_fail=0, synchroniser flops=0. Reset is asynchronous and may assert in any state or mid-countdown; every output takes its reset value immediately.
- Button input:
  - 2-flop synchroniser, then an edge register.
  - press = sync2 & ~sync3.
  - The state update occurs at the 3rd rising clk edge at which btn_next is sampled high.
  - Holding the button produces exactly one press. No debounce is done; that belongs to the upstream block.
- State encoding: IDLE=0, SHOW1=1, SHOW2=2, ENTRY=3, UNLOCKED=4, LOCKOUT=5. Codes 6 and 7 are unreachable and go to IDLE on the next clk.
- Transitions on press:
  - IDLE->SHOW1, SHOW1->SHOW2, SHOW2->ENTRY.
  - ENTRY, all digits match: go to UNLOCKED, fail_cnt<=0, load the unlock timer with UNLOCK_TIMEOUT.
  - ENTRY, any digit mismatches:
    - attempt_fail pulses for exactly the cycle after the press.
    - If fail_cnt+1 == MAX_ATTEMPTS: go to LOCKOUT, fail_cnt<=MAX_ATTEMPTS, load the lockout timer with LOCKOUT_CYCLES-1.
    - Otherwise: fail_cnt<=fail_cnt+1 and stay in ENTRY.
  - UNLOCKED->IDLE.
  - LOCKOUT: presses are ignored.
- Comparison: combinational over all NUM_DIGITS digits, sampled in the press cycle only. Input changes outside the press cycle have no effect.
- LOCKOUT countdown:
  - The timer decrements every clk.
  - In the cycle the timer reads 0, the next edge gives state=IDLE and fail_cnt=0.
  - Total dwell is exactly LOCKOUT_CYCLES cycles.
- UNLOCKED time-out (only when UNLOCK_TIMEOUT>0):
  - The timer decrements every clk; on reaching 0 the state goes to IDLE.
  - If a press and the time-out occur in the same cycle, the result is IDLE with no double action.
- fail_cnt survives IDLE->ENTRY cycling. It is cleared only by a successful match, the end of LOCKOUT, or reset.
- unlocked and locked_out are decoded from the registered state and carry no extra latency.

Decomposition:
- lock_pkg holds:
  - the state localparams (IDLE..LOCKOUT) and STATE_W=3;
  - a clog2 helper function.
- Sub-module btn_sync_edge(clk, rst_n, btn_in, press): the 2-flop synchroniser plus the edge register.
- The lock FSM, comparator and timers stay in lock_sequencer.

Test Plan (use LOCKOUT_CYCLES=10, UNLOCK_TIMEOUT=0 unless stated):
- Reset then 3 presses -> state goes 0,1,2,3. Each change lands 3 clk after btn_next rises. A button held 20 cycles advances the state only once.
- In ENTRY, digits_shown=digits_pw=32'h1234_5678, then press -> state=4, unlocked=1, fail_cnt=0. A further press -> state=0.
- In ENTRY with a wrong code, 2 presses -> two attempt_fail pulses, fail_cnt=2, state stays 3. 3rd wrong press -> state=5, locked_out=1. Presses during lockout are ignored. Exactly 10 cycles later state=0 and fail_cnt=0.
- Two wrong presses, then a correct press -> state=4, fail_cnt=0. A later single wrong attempt does not trigger lockout.
- rst_n low for 1 cycle mid-LOCKOUT (timer=5) -> immediately state=0, locked_out=0, fail_cnt=0.
- With UNLOCK_TIMEOUT=4: unlock -> state returns to 0 after 4 cycles with no press. A press coinciding with the time-out -> state=0.
